uart_rx_framed: RTL and testbench

Parametrised UART receiver, successor to the fixed 8N1 receiver, for the host-link path. Generalises data width, parity, clock/baud ratio and output buffering. Reports parity, framing and overrun errors per frame. Received words are queued in an internal FIFO and drained through a valid/ready handshake, so a stalled consumer no longer loses back-to-back frames.

---
 rtl/uart_pkg.sv | 22 ++
 rtl/uart_rx_fifo.sv | 59 +++++
 rtl/uart_rx_framed.sv | 203 ++++++++++++++++++++
 tb/tb_uart_rx_framed.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: parity encodings, receiver state type and baud divisor helper.
package uart_pkg;

  localparam int unsigned PARITY_NONE = 0;
  localparam int unsigned PARITY_EVEN = 1;
  localparam int unsigned PARITY_ODD  = 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_BREAK
  } rx_state_t;

  function automatic int unsigned cycles_per_baud(input int unsigned clk_hz,
                                                  input int unsigned baud_rate);
    return clk_hz / baud_rate;
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Synchronous FIFO holding received {parity flag, payload} words; head read is zero while empty.
module uart_rx_fifo #(
  parameter int unsigned WIDTH = 9,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             push_in,
  input  logic [WIDTH-1:0] wdata_in,
  input  logic             pop_in,
  output logic [WIDTH-1:0] rdata_out,
  output logic             full_out,
  output logic             empty_out
);

  localparam int unsigned    AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0]    C_DEPTH = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [AW:0]      r_count;
  logic             w_push;
  logic             w_pop;

  assign empty_out = (r_count == '0);
  assign full_out  = (r_count == C_DEPTH);
  assign w_pop     = pop_in && !empty_out;
  // A pop frees the slot in the same cycle, so a full queue still accepts a push.
  assign w_push    = push_in && (!full_out || w_pop);
  assign rdata_out = empty_out ? '0 : r_mem[r_rptr];

  always_ff @(posedge clk_in) begin
    if (w_push) begin
      r_mem[r_wptr] <= wdata_in;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx_framed.sv
// Parametrised UART receiver with parity/framing/overrun reporting and a valid/ready output queue.
// Define UART_RX_MAJORITY_EN for 2-of-3 majority sampling around each sample point.
module uart_rx_framed
  import uart_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 100_000_000,
  parameter int unsigned BAUD_RATE  = 12_000_000,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned PARITY     = 0,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 uart_rx_in,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 parity_err_out,
  output logic                 valid_out,
  input  logic                 ready_in,
  output logic                 frame_err_out,
  output logic                 overrun_out
);

  localparam int unsigned CPB  = cycles_per_baud(CLK_HZ, BAUD_RATE);
  localparam int unsigned CW   = $clog2(CPB);
  localparam int unsigned HALF = CPB / 2;
  localparam int unsigned BW   = $clog2(DATA_BITS + 1);
`ifdef UART_RX_MAJORITY_EN
  localparam int unsigned SAMPLE_LAG = 1;
`else
  localparam int unsigned SAMPLE_LAG = 0;
`endif
  localparam logic [CW-1:0] C_START_PT = CW'(HALF - 1 + SAMPLE_LAG);
  localparam logic [CW-1:0] C_BIT_PT   = CW'(CPB - 1);
  localparam logic [BW-1:0] C_LAST_BIT = BW'(DATA_BITS - 1);

  if (CPB < 4) begin : g_bad_cpb
    $error("uart_rx_framed: CLK_HZ/BAUD_RATE must be >= 4");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_bits
    $error("uart_rx_framed: DATA_BITS must be 5..9");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("uart_rx_framed: FIFO_DEPTH must be a power of two >= 2");
  end

  logic                 r_sync1;
  logic                 r_sync2;
  logic                 w_bit;
  rx_state_t            r_state;
  rx_state_t            w_state_nxt;
  logic [CW-1:0]        r_cnt;
  logic [CW-1:0]        w_cnt_nxt;
  logic [BW-1:0]        r_bitcnt;
  logic [BW-1:0]        w_bitcnt_nxt;
  logic [DATA_BITS-1:0] r_shift;
  logic [DATA_BITS-1:0] w_shift_nxt;
  logic                 r_par_err;
  logic                 w_par_nxt;
  logic                 r_frame_err;
  logic                 w_frame_err_nxt;
  logic                 r_overrun;
  logic                 w_overrun_nxt;
  logic                 w_push;
  logic                 w_pop;
  logic                 w_full;
  logic                 w_empty;
  logic [DATA_BITS:0]   w_head;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= uart_rx_in;
      r_sync2 <= r_sync1;
    end
  end

`ifdef UART_RX_MAJORITY_EN
  logic [1:0] r_hist;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_hist <= '1;
    end else begin
      r_hist <= {r_hist[0], r_sync2};
    end
  end

  // Decided one cycle after the nominal point: votes are nominal-1, nominal, nominal+1.
  assign w_bit = (r_sync2 & r_hist[0]) | (r_sync2 & r_hist[1]) | (r_hist[0] & r_hist[1]);
`else
  assign w_bit = r_sync2;
`endif

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_bitcnt    <= '0;
      r_shift     <= '0;
      r_par_err   <= 1'b0;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_bitcnt    <= w_bitcnt_nxt;
      r_shift     <= w_shift_nxt;
      r_par_err   <= w_par_nxt;
      r_frame_err <= w_frame_err_nxt;
      r_overrun   <= w_overrun_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt + 1'b1;
    w_bitcnt_nxt    = r_bitcnt;
    w_shift_nxt     = r_shift;
    w_par_nxt       = r_par_err;
    w_frame_err_nxt = 1'b0;
    w_overrun_nxt   = 1'b0;
    w_push          = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_cnt_nxt    = '0;
        w_bitcnt_nxt = '0;
        w_par_nxt    = 1'b0;
        if (!r_sync2) begin
          w_state_nxt = S_START;
        end
      end
      S_START: begin
        if (r_cnt == C_START_PT) begin
          w_cnt_nxt   = '0;
          w_state_nxt = w_bit ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (r_cnt == C_BIT_PT) begin
          w_cnt_nxt    = '0;
          w_shift_nxt  = {w_bit, r_shift[DATA_BITS-1:1]};
          w_bitcnt_nxt = r_bitcnt + 1'b1;
          if (r_bitcnt == C_LAST_BIT) begin
            w_state_nxt = (PARITY != PARITY_NONE) ? S_PARITY : S_STOP;
          end
        end
      end
      S_PARITY: begin
        if (r_cnt == C_BIT_PT) begin
          w_cnt_nxt   = '0;
          w_par_nxt   = w_bit ^ (^r_shift) ^ (PARITY == PARITY_ODD);
          w_state_nxt = S_STOP;
        end
      end
      S_STOP: begin
        if (r_cnt == C_BIT_PT) begin
          w_cnt_nxt = '0;
          if (w_bit) begin
            w_state_nxt = S_IDLE;
            if (w_full && !w_pop) begin
              w_overrun_nxt = 1'b1;
            end else begin
              w_push = 1'b1;
            end
          end else begin
            w_frame_err_nxt = 1'b1;
            w_state_nxt     = S_BREAK;
          end
        end
      end
      S_BREAK: begin
        if (r_sync2) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_pop = valid_out && ready_in;

  uart_rx_fifo #(
    .WIDTH (DATA_BITS + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .push_in   (w_push),
    .wdata_in  ({r_par_err, r_shift}),
    .pop_in    (w_pop),
    .rdata_out (w_head),
    .full_out  (w_full),
    .empty_out (w_empty)
  );

  assign valid_out                  = !w_empty;
  assign {parity_err_out, data_out} = w_head;
  assign frame_err_out              = r_frame_err;
  assign overrun_out                = r_overrun;

endmodule

// File: tb/tb_uart_rx_framed.sv
// Scoreboard bench for uart_rx_framed: an 8N1 instance and an even-parity instance at 100 cycles/bit.
module tb_uart_rx_framed;

  localparam int unsigned CPB = 100;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx0 = 1'b1;
  logic       rx1 = 1'b1;
  logic       ready0 = 1'b1;
  logic       ready1 = 1'b1;
  logic [7:0] data0, data1;
  logic       perr0, perr1, valid0, valid1, ferr0, ferr1, ovr0, ovr1;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int unsigned n_ferr0 = 0, n_ovr0 = 0, n_ferr1 = 0, n_ovr1 = 0;
  int unsigned exp_ferr0 = 0, exp_ovr0 = 0;
  int unsigned n_extra0 = 0, n_extra1 = 0;
  logic [8:0]  exp0_q[$];
  logic [8:0]  exp1_q[$];

  always #5 clk = ~clk;

  uart_rx_framed #(
    .CLK_HZ(100_000_000), .BAUD_RATE(1_000_000), .DATA_BITS(8), .PARITY(0), .FIFO_DEPTH(4)
  ) dut (
    .clk_in(clk), .rst_in(rst), .uart_rx_in(rx0), .data_out(data0), .parity_err_out(perr0),
    .valid_out(valid0), .ready_in(ready0), .frame_err_out(ferr0), .overrun_out(ovr0)
  );

  uart_rx_framed #(
    .CLK_HZ(100_000_000), .BAUD_RATE(1_000_000), .DATA_BITS(8), .PARITY(1), .FIFO_DEPTH(4)
  ) dut_par (
    .clk_in(clk), .rst_in(rst), .uart_rx_in(rx1), .data_out(data1), .parity_err_out(perr1),
    .valid_out(valid1), .ready_in(ready1), .frame_err_out(ferr1), .overrun_out(ovr1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (valid0 && ready0) begin
        if (exp0_q.size() == 0) begin
          n_extra0++;
        end else begin
          logic [8:0] e;
          e = exp0_q.pop_front();
          check("data0", 32'(data0), 32'(e[7:0]));
          check("perr0", 32'(perr0), 32'(e[8]));
        end
      end
      if (valid1 && ready1) begin
        if (exp1_q.size() == 0) begin
          n_extra1++;
        end else begin
          logic [8:0] e;
          e = exp1_q.pop_front();
          check("data1", 32'(data1), 32'(e[7:0]));
          check("perr1", 32'(perr1), 32'(e[8]));
        end
      end
      if (ferr0) n_ferr0++;
      if (ovr0)  n_ovr0++;
      if (ferr1) n_ferr1++;
      if (ovr1)  n_ovr1++;
    end
  end

  task automatic drive(input int unsigned which, input logic v);
    if (which == 0) rx0 = v;
    else            rx1 = v;
  endtask

  task automatic wait_cycles(input int unsigned n);
    repeat (n) @(negedge clk);
  endtask

  // spike_bit >= 0 puts a one-cycle high pulse at the centre of that data bit.
  task automatic send_frame(input int unsigned which, input logic [7:0] d, input bit use_par,
                            input logic par, input logic stop, input int spike_bit);
    drive(which, 1'b0);
    wait_cycles(CPB);
    for (int i = 0; i < 8; i++) begin
      drive(which, d[i]);
      if (i == spike_bit) begin
        wait_cycles(CPB / 2);
        drive(which, 1'b1);
        wait_cycles(1);
        drive(which, d[i]);
        wait_cycles(CPB / 2 - 1);
      end else begin
        wait_cycles(CPB);
      end
    end
    if (use_par) begin
      drive(which, par);
      wait_cycles(CPB);
    end
    drive(which, stop);
    wait_cycles(CPB);
  endtask

  task automatic wait_drain(input int unsigned budget);
    int unsigned n;
    n = 0;
    while ((exp0_q.size() != 0 || exp1_q.size() != 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("drain0", 32'(exp0_q.size()), 32'd0);
    check("drain1", 32'(exp1_q.size()), 32'd0);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    wait_cycles(5);
    rst = 1'b0;
    check("rst_valid", 32'(valid0), 32'd0);
    check("rst_data",  32'(data0),  32'd0);
    check("rst_perr",  32'(perr0),  32'd0);
    check("rst_ferr",  32'(ferr0),  32'd0);
    check("rst_ovr",   32'(ovr0),   32'd0);
    wait_cycles(20);

    // 8N1 0xA5
    exp0_q.push_back({1'b0, 8'hA5});
    send_frame(0, 8'hA5, 0, 1'b0, 1'b1, -1);
    wait_cycles(CPB);
    wait_drain(500);

    // Even parity: 0x07 with wrong then correct parity bit
    exp1_q.push_back({1'b1, 8'h07});
    send_frame(1, 8'h07, 1, 1'b0, 1'b1, -1);
    exp1_q.push_back({1'b0, 8'h07});
    send_frame(1, 8'h07, 1, 1'b1, 1'b1, -1);
    wait_cycles(CPB);
    wait_drain(500);

    // Framing error followed by held-low break, then recovery
    send_frame(0, 8'h3C, 0, 1'b0, 1'b0, -1);
    exp_ferr0++;
    wait_cycles(5 * CPB);
    rx0 = 1'b1;
    wait_cycles(2 * CPB);
    check("ferr_count", n_ferr0, exp_ferr0);
    check("break_noentry", 32'(valid0), 32'd0);
    exp0_q.push_back({1'b0, 8'h11});
    send_frame(0, 8'h11, 0, 1'b0, 1'b1, -1);
    wait_cycles(CPB);
    wait_drain(500);

    // 30-cycle glitch is a false start
    rx0 = 1'b0;
    wait_cycles(30);
    rx0 = 1'b1;
    wait_cycles(2 * CPB);
    check("glitch_valid", 32'(valid0), 32'd0);
    check("glitch_ferr", n_ferr0, exp_ferr0);

`ifdef UART_RX_MAJORITY_EN
    exp0_q.push_back({1'b0, 8'h00});
    send_frame(0, 8'h00, 0, 1'b0, 1'b1, 2);
    wait_cycles(CPB);
    wait_drain(500);
`endif

    // Five back-to-back frames into a stalled 4-entry queue
    ready0 = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      if (i <= 4) exp0_q.push_back({1'b0, 8'(i)});
      send_frame(0, 8'(i), 0, 1'b0, 1'b1, -1);
    end
    exp_ovr0++;
    wait_cycles(CPB);
    check("ovr_count", n_ovr0, exp_ovr0);
    check("ovr_valid", 32'(valid0), 32'd1);
    check("ovr_head_stable", 32'(data0), 32'h01);
    ready0 = 1'b1;
    wait_drain(50);

    // Reset mid-frame with a queued entry
    ready0 = 1'b0;
    exp0_q.push_back({1'b0, 8'h33});
    send_frame(0, 8'h33, 0, 1'b0, 1'b1, -1);
    wait_cycles(CPB);
    check("pre_rst_valid", 32'(valid0), 32'd1);
    check("pre_rst_data", 32'(data0), 32'h33);
    rx0 = 1'b0;
    wait_cycles(CPB);
    for (int i = 0; i < 4; i++) begin
      rx0 = 1'(8'h5A >> i);
      wait_cycles(CPB);
    end
    rx0 = 1'b1;
    wait_cycles(CPB / 2);
    rst = 1'b1;
    exp0_q.delete();
    wait_cycles(1);
    rst = 1'b0;
    check("mid_rst_valid", 32'(valid0), 32'd0);
    check("mid_rst_data",  32'(data0),  32'd0);
    check("mid_rst_perr",  32'(perr0),  32'd0);
    check("mid_rst_ferr",  32'(ferr0),  32'd0);
    check("mid_rst_ovr",   32'(ovr0),   32'd0);
    wait_cycles(3 * CPB);
    check("partial_noentry", 32'(valid0), 32'd0);
    ready0 = 1'b1;
    exp0_q.push_back({1'b0, 8'h5A});
    send_frame(0, 8'h5A, 0, 1'b0, 1'b1, -1);
    wait_cycles(CPB);
    wait_drain(500);

    check("final_ferr0", n_ferr0, exp_ferr0);
    check("final_ovr0", n_ovr0, exp_ovr0);
    check("final_ferr1", n_ferr1, 32'd0);
    check("final_ovr1", n_ovr1, 32'd0);
    check("extra0", n_extra0, 32'd0);
    check("extra1", n_extra1, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
